// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning the HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by MDU_MADD_EN.
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             op_ready,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] LAST_MUL = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] LAST_ACC = CW'(MUL_LAT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL      = 3'd1;
    localparam logic [2:0] S_DIV_PRE  = 3'd2;
    localparam logic [2:0] S_DIV_ITER = 3'd3;
    localparam logic [2:0] S_DIV_FIX  = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [W2-1:0]    p_pipe [MUL_LAT];
    logic [W2-1:0]    mul_a;
    logic [W2-1:0]    mul_b;
    logic [W2-1:0]    product;
    logic [W2-1:0]    hilo;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             sgn_r;
    logic             acc_r;
    logic             sub_r;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             is_mul;
    logic             is_div;
    logic             is_mthi;
    logic             is_mtlo;
    logic             is_acc;
    logic             is_sub;
    logic             op_sgn;
    logic             accept;

    assign busy     = (state != S_IDLE);
    assign op_ready = ~busy;
    assign accept   = ~busy & op_valid & ~kill;
    assign hilo     = {hi, lo};

    // Decode the op code into operation class and signedness.
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        is_acc  = 1'b0;
        is_sub  = 1'b0;
        op_sgn  = 1'b0;
        case (op)
            4'd0: begin is_mul = 1'b1; op_sgn = 1'b1; end
            4'd1: is_mul = 1'b1;
            4'd2: begin is_div = 1'b1; op_sgn = 1'b1; end
            4'd3: is_div = 1'b1;
            4'd4: is_mthi = 1'b1;
            4'd5: is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            4'd6: begin is_mul = 1'b1; is_acc = 1'b1; op_sgn = 1'b1; end
            4'd7: begin is_mul = 1'b1; is_acc = 1'b1; end
            4'd8: begin
                is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; op_sgn = 1'b1;
            end
            4'd9: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Extend operands to double width; the low 2*WIDTH bits of the product
    // are correct for both signed and unsigned operands.
    always_comb begin
        mul_a   = op_sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        mul_b   = op_sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        product = mul_a * mul_b;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
    end

    // Datapath: operand latch, product chain and restoring divider.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r       <= a;
            b_r       <= b;
            sgn_r     <= op_sgn;
            acc_r     <= is_acc;
            sub_r     <= is_sub;
            p_pipe[0] <= product;
        end
        if (state == S_MUL) begin
            for (int i = 1; i < MUL_LAT; i++) begin
                p_pipe[i] <= p_pipe[i-1];
            end
        end
        if (state == S_DIV_PRE) begin
            dvs      <= (sgn_r & b_r[WIDTH-1]) ? -b_r : b_r;
            quo      <= (sgn_r & a_r[WIDTH-1]) ? -a_r : a_r;
            rem      <= '0;
            neg_q    <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_r    <= sgn_r & a_r[WIDTH-1];
            div_zero <= (b_r == '0);
            iter     <= WIDTH'(1);
        end
        if (state == S_DIV_ITER) begin
            rem  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            iter <= {iter[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM and the architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        if (is_mthi) hi <= a;
                        if (is_mtlo) lo <= a;
                        if (is_mul) begin
                            state <= S_MUL;
                            cnt   <= '0;
                        end
                        if (is_div) state <= S_DIV_PRE;
                    end
                end
                S_MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == (acc_r ? LAST_ACC : LAST_MUL)) begin
                        state <= S_IDLE;
                        if (!acc_r) begin
                            {hi, lo} <= p_pipe[MUL_LAT-1];
                        end else if (sub_r) begin
                            {hi, lo} <= hilo - p_pipe[MUL_LAT-1];
                        end else begin
                            {hi, lo} <= hilo + p_pipe[MUL_LAT-1];
                        end
                    end
                end
                S_DIV_PRE: state <= S_DIV_ITER;
                S_DIV_ITER: begin
                    if (iter[WIDTH-1]) state <= S_DIV_FIX;
                end
                S_DIV_FIX: begin
                    state <= S_IDLE;
                    if (div_zero) begin
                        lo <= '1;
                        hi <= a_r;
                    end else begin
                        lo <= neg_q ? -quo : quo;
                        hi <= neg_r ? -rem : rem;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter checked against an
// arithmetic reference model every cycle plus literal expectations.
module tb_mdu_iter;

    localparam int W  = 32;
    localparam int ML = 2;

    logic          clk;
    logic          rst;
    logic          op_valid;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          kill;
    logic          op_ready;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .kill     (kill),
        .op_ready (op_ready),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t)",
                         name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op produces its result after a fixed
    // number of cycles, unless a kill or reset intervenes first.
    logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
    logic [63:0]   p_prod;
    logic [127:0]  acc_sum;
    bit            p_acc, p_sub, m_on;
    int            left = 0;
    longint        sa, sb;

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0;
            m_lo = '0;
            left = 0;
            m_on = 1'b1;
        end else if (kill) begin
            left = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                if (p_acc) begin
                    if (p_sub) acc_sum = {m_hi, m_lo} - p_prod;
                    else       acc_sum = {m_hi, m_lo} + p_prod;
                    {m_hi, m_lo} = acc_sum[63:0];
                end else begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (op_valid) begin
            p_acc = 1'b0;
            p_sub = 1'b0;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                4'd0, 4'd1: begin
                    if (op == 4'd0) p_prod = sa * sb;
                    else p_prod = {32'b0, a} * {32'b0, b};
                    {p_hi, p_lo} = p_prod;
                    left = ML;
                end
                4'd2: begin
                    if (b == 0) begin
                        p_lo = '1; p_hi = a;
                    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        p_lo = 32'h8000_0000; p_hi = '0;
                    end else begin
                        p_lo = 32'(sa / sb);
                        p_hi = 32'(sa % sb);
                    end
                    left = W + 2;
                end
                4'd3: begin
                    if (b == 0) begin
                        p_lo = '1; p_hi = a;
                    end else begin
                        p_lo = a / b;
                        p_hi = a % b;
                    end
                    left = W + 2;
                end
                4'd4: m_hi = a;
                4'd5: m_lo = a;
`ifdef MDU_MADD_EN
                4'd6, 4'd7, 4'd8, 4'd9: begin
                    if (op == 4'd6 || op == 4'd8) p_prod = sa * sb;
                    else p_prod = {32'b0, a} * {32'b0, b};
                    p_acc = 1'b1;
                    p_sub = (op >= 4'd8);
                    left  = ML + 1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            chk("busy", 64'(busy), 64'(left > 0));
            chk("op_ready", 64'(op_ready), 64'(left == 0));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        op_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 4'hF;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    typedef struct {
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    vec_t vecs [8] = '{
        '{4'd2, 32'd7,         32'hFFFF_FFFE},
        '{4'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE},
        '{4'd3, 32'd100,       32'd7},
        '{4'd3, 32'hFFFF_FFFF, 32'd1},
        '{4'd2, 32'hFFFF_FFFB, 32'd0},
        '{4'd0, 32'h8000_0000, 32'h8000_0000},
        '{4'd1, 32'h1234_5678, 32'h9ABC_DEF0},
        '{4'hC, 32'hDEAD_BEEF, 32'd3}
    };

    int n;

    initial begin
        rst = 1'b1;
        kill = 1'b0;
        op_valid = 1'b1;
        op = 4'd4;
        a = 32'h55;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        op_valid = 1'b0;
        op = 4'hF;
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ready", 64'(op_ready), 64'h1);

        issue(4'd0, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        chk("mult_lat", 64'(n), 64'(ML));
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFE);
        issue(4'd1, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_lat", 64'(n), 64'd34);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        issue(4'd3, 32'd7, 32'd0);
        wait_idle(n);
        chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(hi), 64'h7);

        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1;
        op_valid = 1'b1;
        op = 4'd5;
        a = 32'hBEEF;
        wait_idle(n);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);
        chk("ovf_hi", 64'(hi), 64'h0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 4'hF;
        chk("held_mtlo", 64'(lo), 64'hBEEF);

        issue(4'd4, 32'h1234, 32'd0);
        issue(4'd3, 32'd100, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_busy", 64'(busy), 64'h0);
        chk("kill_hi", 64'(hi), 64'h1234);
        chk("kill_lo", 64'(lo), 64'hBEEF);
        op_valid = 1'b1;
        op = 4'd5;
        a = 32'h55;
        kill = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        kill = 1'b0;
        op = 4'hF;
        chk("kill_mtlo", 64'(lo), 64'hBEEF);

        issue(4'd0, 32'd3, 32'd5);
        repeat (ML - 1) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_end_hi", 64'(hi), 64'h1234);
        chk("kill_end_lo", 64'(lo), 64'hBEEF);

        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].x, vecs[i].y);
            wait_idle(n);
        end

        issue(4'd4, 32'd0, 32'd0);
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        issue(4'd9, 32'd1, 32'd1);
        wait_idle(n);
`ifdef MDU_MADD_EN
        chk("madd_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("madd_lo", 64'(lo), 64'h0);
`else
        chk("madd_nop_hi", 64'(hi), 64'h0);
        chk("madd_nop_lo", 64'(lo), 64'h0);
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
